// File: rtl/pwm_multichannel.sv
// pwm_multichannel
// Multi-channel PWM generator. A single prescaled WIDTH-bit counter is shared by all
// channels. Each channel has its own double-buffered duty register: software writes
// the pending copy, and the whole bank is copied to the active copy at a period boundary.
// The counter runs edge-aligned (sawtooth) or centre-aligned (triangle). The mode is
// latched only at a boundary, so a period always completes in the shape it started with.
module pwm_multichannel #(
    parameter  int NCH     = 16,
    parameter  int WIDTH   = 8,
    parameter  int PRESC_W = 8,
    localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     en_out,
    input  logic [NCH-1:0]     en_pwm,
    input  logic               duty_we,
    input  logic [SEL_W-1:0]   duty_sel,
    input  logic [WIDTH-1:0]   duty_wdata,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               center_mode,
    output logic [NCH-1:0]     out,
    output logic               period_start
);

    // Highest counter value reached; MAX = 2**WIDTH-1 is never reached, so duty MAX
    // compares true on every count value and gives a constant-high output.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic {
        MODE_EDGE,
        MODE_CENTER
    } mode_t;

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;
    logic [WIDTH-1:0]   cnt;
    logic [WIDTH-1:0]   cnt_next;
    dir_t               dir;
    dir_t               dir_next;
    mode_t              mode;
    logic               boundary;
    logic               sel_valid;
    logic [NCH-1:0]     raw;
    logic [WIDTH-1:0]   pending_duty [NCH];
    logic [WIDTH-1:0]   active_duty  [NCH];

    // A write to a channel that does not exist is dropped. When NCH fills the whole
    // select range, every select value is a real channel.
    if (NCH == (1 << SEL_W)) begin : g_sel_full
        assign sel_valid = 1'b1;
    end else begin : g_sel_part
        assign sel_valid = (duty_sel < SEL_W'(NCH));
    end

    // Prescaler tick: '>=' rather than '==' so lowering prescale below the current
    // count fires on the next clock instead of wrapping the counter around.
    always_comb begin
        tick = (presc_cnt >= prescale);
    end

    // Next counter value and direction, plus detection of the period boundary.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch; a path
        // that left one unassigned would make synthesis infer a latch.
        cnt_next = cnt;
        dir_next = dir;
        boundary = 1'b0;
        if (tick) begin
            if (mode == MODE_EDGE) begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else if (dir == DIR_UP) begin
                // Top endpoint repeats: turn around without moving the count.
                if (cnt == CNT_LAST) begin
                    dir_next = DIR_DOWN;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end else begin
                // Bottom endpoint repeats: the turn-around tick is the boundary.
                if (cnt == '0) begin
                    dir_next = DIR_UP;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt - WIDTH'(1);
                end
            end
        end
    end

    // Prescaler, shared counter, direction, latched mode and the period_start pulse.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values, independent of statement order within the block.
        if (!rst_n) begin
            presc_cnt    <= '0;
            cnt          <= '0;
            dir          <= DIR_UP;
            mode         <= MODE_EDGE;
            period_start <= 1'b0;
        end else begin
            presc_cnt    <= tick ? '0 : presc_cnt + PRESC_W'(1);
            period_start <= boundary;
            if (boundary) begin
                // New period: pick up the requested mode and restart from the bottom.
                cnt  <= '0;
                dir  <= DIR_UP;
                mode <= center_mode ? MODE_CENTER : MODE_EDGE;
            end else begin
                cnt  <= cnt_next;
                dir  <= dir_next;
            end
        end
    end

    // Double-buffered duty bank: writes land in pending, boundary copies pending to active.
    always_ff @(posedge clk) begin
        // NOTE: the duty bank is a set of plain flops, not a RAM, so it is cleared on
        // reset; otherwise the first period after reset would run with stale duties.
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                pending_duty[i] <= '0;
                active_duty[i]  <= '0;
            end
        end else begin
            // Same-cycle write and boundary: active takes the old pending value and the
            // new value waits in pending for the following boundary.
            if (boundary) begin
                for (int i = 0; i < NCH; i++) begin
                    active_duty[i] <= pending_duty[i];
                end
            end
            if (duty_we && sel_valid) begin
                pending_duty[duty_sel] <= duty_wdata;
            end
        end
    end

    // Per-channel compare of the shared counter against the active duty.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NCH; i++) begin
            raw[i] = (cnt < active_duty[i]);
        end
    end

    // Registered outputs: gated by en_out, forced high when PWM is disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                out[i] <= en_out[i] & (en_pwm[i] ? raw[i] : 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel
// Directed bench for pwm_multichannel. A behavioural model tracks the position inside
// the current period as a plain tick index and derives the counter value arithmetically;
// the DUT outputs are compared against it every clock. A window monitor measures each
// whole period of DUT output, and hand-computed literals pin period lengths, high
// counts and symmetry. NCH=12 so that out-of-range channel selects exist.
module tb_pwm_multichannel;

    localparam int NCH     = 12;
    localparam int WIDTH   = 8;
    localparam int PRESC_W = 8;
    localparam int SEL_W   = 4;
    localparam int MAX     = (1 << WIDTH) - 1;
    localparam logic [NCH-1:0] ALL_ONES = '1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NCH-1:0]     en_out;
    logic [NCH-1:0]     en_pwm;
    logic               duty_we;
    logic [SEL_W-1:0]   duty_sel;
    logic [WIDTH-1:0]   duty_wdata;
    logic [PRESC_W-1:0] prescale;
    logic               center_mode;
    logic [NCH-1:0]     dut_out;
    logic               dut_ps;

    int vectors     = 0;
    int miscompares = 0;

    pwm_multichannel #(
        .NCH    (NCH),
        .WIDTH  (WIDTH),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_out      (en_out),
        .en_pwm      (en_pwm),
        .duty_we     (duty_we),
        .duty_sel    (duty_sel),
        .duty_wdata  (duty_wdata),
        .prescale    (prescale),
        .center_mode (center_mode),
        .out         (dut_out),
        .period_start(dut_ps)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_presc = 0;
    int           m_phase = 0;      // ticks elapsed in the current period
    bit           m_mode  = 1'b0;   // 0 edge, 1 centre
    int           m_pend [NCH];
    int           m_act  [NCH];
    logic [NCH-1:0] m_out = '0;
    logic         m_ps    = 1'b0;
    int           m_ticks = 0;
    int           m_c;
    bit           m_tk;
    bit           m_bnd;

    function automatic int model_cnt();
        if (!m_mode) return m_phase;
        return (m_phase < MAX) ? m_phase : (2 * MAX - 1 - m_phase);
    endfunction

    function automatic int period_len();
        return m_mode ? 2 * MAX : MAX;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_presc = 0;
            m_phase = 0;
            m_mode  = 1'b0;
            m_ps    = 1'b0;
            m_out   = '0;
            for (int i = 0; i < NCH; i++) begin
                m_pend[i] = 0;
                m_act[i]  = 0;
            end
        end else begin
            m_c = model_cnt();
            for (int i = 0; i < NCH; i++)
                m_out[i] = en_out[i] & (en_pwm[i] ? (m_c < m_act[i]) : 1'b1);
            m_tk    = (m_presc >= int'(prescale));
            m_presc = m_tk ? 0 : m_presc + 1;
            m_bnd   = m_tk && (m_phase == period_len() - 1);
            m_ps    = m_bnd;
            if (m_bnd) begin
                m_act   = m_pend;
                m_mode  = center_mode;
                m_phase = 0;
            end else if (m_tk) begin
                m_phase++;
            end
            if (m_tk) m_ticks++;
            if (duty_we && int'(duty_sel) < NCH) m_pend[duty_sel] = int'(duty_wdata);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of DUT against model.
    initial forever begin
        @(posedge clk);
        #1;
        check("out", dut_out, m_out);
        check("period_start", dut_ps, m_ps);
    end

    // ---------------- period window monitor ----------------
    // A window opens on the sample after period_start, where out first reflects cnt=0.
    int run_high [NCH];
    int last_high[NCH];
    int run_len = 0, last_len = 0;
    int run_first_low = -1, run_last_low = -1;
    int last_first_low = -1, last_last_low = -1;
    int ps_count = 0;
    int mon_ch = 0;
    bit ps_d = 1'b0;

    initial begin
        for (int i = 0; i < NCH; i++) run_high[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ps_d) begin
                last_high      = run_high;
                last_len       = run_len;
                last_first_low = run_first_low;
                last_last_low  = run_last_low;
                for (int i = 0; i < NCH; i++) run_high[i] = 0;
                run_len       = 0;
                run_first_low = -1;
                run_last_low  = -1;
                ps_count++;
            end
            for (int i = 0; i < NCH; i++) run_high[i] += (dut_out[i] === 1'b1) ? 1 : 0;
            if (dut_out[mon_ch] !== 1'b1) begin
                if (run_first_low < 0) run_first_low = run_len;
                run_last_low = run_len;
            end
            run_len++;
            ps_d = (dut_ps === 1'b1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ps();
        int n = ps_count;
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(posedge clk);
            #2;
            if (ps_count != n) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ps: no period boundary within 3000 clks (t=%0t)", $time);
        end
    endtask

    task automatic write_duty(input int sel, input int val);
        @(negedge clk);
        duty_we    = 1'b1;
        duty_sel   = sel[SEL_W-1:0];
        duty_wdata = val[WIDTH-1:0];
        @(negedge clk);
        duty_we    = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int exp_h[NCH];
        int t0;
        bit hit;

        rst_n       = 1'b0;
        en_out      = '1;
        en_pwm      = '0;
        duty_we     = 1'b0;
        duty_sel    = '0;
        duty_wdata  = '0;
        prescale    = '0;
        center_mode = 1'b0;

        // 1: reset holds outputs low, then static-high channels come up one clk later.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_out", dut_out, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("release_out", dut_out, ALL_ONES);

        // 2: edge mode, ch3 duty 64 -> 64 high of every 255 clks.
        @(negedge clk);
        en_pwm = '1;
        mon_ch = 3;
        write_duty(3, 64);
        wait_ps();
        wait_ps();
        check("edge_ch3_high", last_high[3], 64);
        check("edge_period_len", last_len, 255);

        // 3: double buffering of ch0.
        mon_ch = 0;
        write_duty(0, 200);
        wait_ps();
        repeat (100) @(negedge clk);
        write_duty(0, 10);
        wait_ps();
        check("dbuf_current_200", last_high[0], 200);
        wait_ps();
        check("dbuf_next_10", last_high[0], 10);
        repeat (253) @(negedge clk);
        write_duty(0, 50);              // lands on the boundary edge
        wait_ps();
        check("bnd_write_prev", last_high[0], 10);
        wait_ps();
        check("bnd_write_delayed", last_high[0], 10);
        wait_ps();
        check("bnd_write_applied", last_high[0], 50);

        // 4: extremes and an out-of-range select.
        write_duty(2, 255);
        write_duty(1, 0);
        write_duty(NCH, 77);
        wait_ps();
        wait_ps();
        exp_h = '{50, 0, 255, 64, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < NCH; i++) check($sformatf("extreme_ch%0d", i), last_high[i], exp_h[i]);
        check("extreme_len", last_len, 255);

        // 5: centre mode, ch5 duty 100.
        mon_ch = 5;
        write_duty(5, 100);
        @(negedge clk);
        center_mode = 1'b1;
        wait_ps();
        wait_ps();
        check("centre_len", last_len, 510);
        check("centre_high", last_high[5], 200);
        check("centre_first_low", last_first_low, 100);
        check("centre_last_low", last_last_low, 409);
        repeat (200) @(negedge clk);
        center_mode = 1'b0;             // mid-period: ignored until the boundary
        wait_ps();
        check("mode_hold_len", last_len, 510);
        wait_ps();
        check("mode_switch_len", last_len, 255);

        // 6: prescaler.
        write_duty(6, 128);
        @(negedge clk);
        prescale = 8'd3;
        wait_ps();
        wait_ps();
        check("presc3_len", last_len, 1020);
        check("presc3_high", last_high[6], 512);
        @(negedge clk);
        prescale = 8'd200;
        hit = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(posedge clk);
            #2;
            if (m_presc == 150) hit = 1'b1;
        end
        check("presc_reach_150", hit, 1);
        @(negedge clk);
        t0 = m_ticks;
        prescale = 8'd2;
        @(posedge clk);
        #2;
        check("presc_drop_tick", m_ticks, t0 + 1);
        check("presc_drop_clear", m_presc, 0);
        wait_ps();
        wait_ps();
        check("presc2_len", last_len, 765);
        check("presc2_high", last_high[6], 384);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
